// File: rtl/sw_alloc_pkg.sv
// rtl/sw_alloc_pkg.sv - shared constants and types for the switch allocator
package sw_alloc_pkg;

    // NPORT must stay a power of two: the round-robin scan relies on index wrap.
    localparam int NPORT = 4;
    localparam int CREDW = 3;
    localparam int PIDXW = $clog2(NPORT);
    localparam logic [CREDW-1:0] CRED_INIT = CREDW'(4);

    typedef logic [PIDXW-1:0] port_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } out_state_e;

endpackage

// File: rtl/sw_alloc_if.sv
// rtl/sw_alloc_if.sv - request/credit inputs and grant/fire/pop outputs of the allocator
interface sw_alloc_if;
    import sw_alloc_pkg::*;

    logic [NPORT*NPORT-1:0] req;
    logic [NPORT-1:0]       tail;
    logic [NPORT-1:0]       cred_ret;
    logic [NPORT*NPORT-1:0] grant;
    logic [NPORT-1:0]       fire;
    logic [NPORT-1:0]       pop;
    logic                   err;

    modport master (
        output req, tail, cred_ret,
        input  grant, fire, pop, err
    );

    modport slave (
        input  req, tail, cred_ret,
        output grant, fire, pop, err
    );

endinterface

// File: rtl/sw_alloc_rr_pick.sv
// rtl/sw_alloc_rr_pick.sv - combinational round-robin picker, first request after ptr wins
module sw_alloc_rr_pick
    import sw_alloc_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  port_idx_t        ptr,
    output logic [NPORT-1:0] gnt,
    output port_idx_t        idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = ptr;
        any = 1'b0;
        // ptr+NPORT wraps back to ptr itself, so the last owner has lowest priority.
        for (int k = 1; k <= NPORT; k++) begin
            if (!any && req[ptr + port_idx_t'(k)]) begin
                any = 1'b1;
                idx = ptr + port_idx_t'(k);
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sw_alloc.sv
// rtl/sw_alloc.sv - wormhole switch allocator with per-output round robin and credit pacing
module sw_alloc
    import sw_alloc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    sw_alloc_if.slave bus
);

    logic [NPORT-1:0] req_by_out [NPORT];   // [o][i]
    logic [NPORT-1:0] grant_all  [NPORT];   // [o][i]
    logic [NPORT-1:0] owned_by   [NPORT];   // [i][o]
    logic [NPORT-1:0] owns_any;
    logic [NPORT-1:0] fire;
    logic [NPORT-1:0] err_set;
    logic             err_q, err_d;

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_in
        for (genvar go = 0; go < NPORT; go++) begin : g_cross
            assign req_by_out[go][gi]     = bus.req[gi*NPORT+go];
            assign owned_by[gi][go]       = grant_all[go][gi];
            assign bus.grant[go*NPORT+gi] = grant_all[go][gi];
        end
        assign owns_any[gi] = |owned_by[gi];
        assign bus.pop[gi]  = |(fire & owned_by[gi]);
    end

    for (genvar go = 0; go < NPORT; go++) begin : g_out
        out_state_e       state_q, state_d;
        port_idx_t        owner_q, owner_d;
        port_idx_t        ptr_q, ptr_d;
        logic [NPORT-1:0] grant_q, grant_d;
        logic [CREDW-1:0] cred_q, cred_d;
        logic [NPORT-1:0] elig, pick_oh;
        port_idx_t        pick_idx;
        logic             pick_any;
        logic             fire_o, has_cred;

        // An input already holding another output cannot start a second packet.
        assign elig = req_by_out[go] & ~owns_any;

        sw_alloc_rr_pick u_pick (
            .req (elig),
            .ptr (ptr_q),
            .gnt (pick_oh),
            .idx (pick_idx),
            .any (pick_any)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= port_idx_t'(NPORT-1);
                grant_q <= '0;
                cred_q  <= CRED_INIT;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
                grant_q <= grant_d;
                cred_q  <= cred_d;
            end
        end

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            grant_d = grant_q;
            case (state_q)
                IDLE: begin
                    if (pick_any && has_cred) begin
                        state_d = BUSY;
                        owner_d = pick_idx;
                        grant_d = pick_oh;
                    end
                end
                BUSY: begin
                    if (fire_o && bus.tail[owner_q]) begin
                        state_d = IDLE;
                        ptr_d   = owner_q;
                        grant_d = '0;
                    end
                end
                default: ;
            endcase

            cred_d = cred_q;
            if (fire_o && !bus.cred_ret[go]) begin
                cred_d = cred_q - CREDW'(1);
            end else if (!fire_o && bus.cred_ret[go] && cred_q != CRED_INIT) begin
                cred_d = cred_q + CREDW'(1);
            end
        end

        always_comb begin
            has_cred = (cred_q != '0);
            fire_o   = (state_q == BUSY) && req_by_out[go][owner_q] && has_cred;
        end

        assign fire[go]      = fire_o;
        assign grant_all[go] = grant_q;
        assign err_set[go]   = bus.cred_ret[go] && !fire_o && (cred_q == CRED_INIT);
    end

    always_comb begin
        err_d = err_q | (|err_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.fire = fire;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_sw_alloc.sv
// tb/tb_sw_alloc.sv - self-checking bench for sw_alloc
module tb_sw_alloc;
    import sw_alloc_pkg::*;

    localparam int NP = NPORT;
    localparam int NR = NPORT * NPORT;
    localparam int CI = int'(CRED_INIT);

    localparam logic [3:0] T2_GRANT [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0};
    localparam logic       T2_FIRE  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst_n;

    sw_alloc_if bus ();

    sw_alloc dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model: owner -1 means the output is free.
    int m_owner [NP];
    int m_ptr   [NP];
    int m_cred  [NP];
    bit m_fire  [NP];
    bit m_owned [NP];
    bit m_err;
    int mc;

    // Upstream buffers: flits left in the current packet and its destination.
    int rem [NP];
    int dst [NP];
    logic [NP-1:0] auto_ret = '0;
    logic [NP-1:0] man_ret  = '0;
    logic [NR-1:0] drv_req;
    logic [NP-1:0] drv_tail, drv_ret;
    logic [NR-1:0] exp_grant;
    logic [NP-1:0] exp_fire, exp_pop;
    int nf;
    int nreq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit bit_of(input logic [31:0] v, input int n);
        logic [31:0] s;
        s = v >> n;
        return s[0];
    endfunction

    function automatic bit req_bit(input int i, input int o);
        logic [NR-1:0] s;
        s = bus.req >> (i * NP + o);
        return s[0];
    endfunction

    // Model update on each clock edge, reset asynchronously.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int o = 0; o < NP; o++) begin
                m_owner[o] = -1;
                m_ptr[o]   = NP - 1;
                m_cred[o]  = CI;
            end
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < NP; i++) m_owned[i] = 1'b0;
            for (int o = 0; o < NP; o++) if (m_owner[o] >= 0) m_owned[m_owner[o]] = 1'b1;
            for (int o = 0; o < NP; o++)
                m_fire[o] = (m_owner[o] >= 0) && req_bit(m_owner[o], o) && (m_cred[o] > 0);
            for (int o = 0; o < NP; o++) begin
                if (m_owner[o] < 0) begin
                    if (m_cred[o] > 0) begin
                        for (int k = 1; k <= NP; k++) begin
                            mc = (m_ptr[o] + k) % NP;
                            if (m_owner[o] < 0 && req_bit(mc, o) && !m_owned[mc]) m_owner[o] = mc;
                        end
                    end
                end else if (m_fire[o] && bit_of(32'(bus.tail), m_owner[o])) begin
                    m_ptr[o]   = m_owner[o];
                    m_owner[o] = -1;
                end
                if (m_fire[o] && !bit_of(32'(bus.cred_ret), o)) begin
                    m_cred[o] = m_cred[o] - 1;
                end else if (!m_fire[o] && bit_of(32'(bus.cred_ret), o)) begin
                    if (m_cred[o] == CI) m_err = 1'b1;
                    else m_cred[o] = m_cred[o] + 1;
                end
            end
        end
    end

    // Input driver: head flits from rem/dst, credit returns shortly after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        drv_req  = '0;
        drv_tail = '0;
        drv_ret  = man_ret;
        man_ret  = '0;
        for (int i = 0; i < NP; i++) begin
            if (rem[i] > 0) begin
                drv_req = drv_req | (NR'(1) << (i * NP + dst[i]));
                if (rem[i] == 1) drv_tail = drv_tail | (NP'(1) << i);
            end
        end
        for (int o = 0; o < NP; o++)
            if (bit_of(32'(auto_ret), o) && m_cred[o] < CI) drv_ret = drv_ret | (NP'(1) << o);
        bus.req      = drv_req;
        bus.tail     = drv_tail;
        bus.cred_ret = drv_ret;
    end

    // Buffer dequeue on pop.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NP; i++)
            if (bit_of(32'(bus.pop), i) && rem[i] > 0) rem[i] = rem[i] - 1;
    end

    // Compare process: DUT against the model on every cycle.
    initial forever begin
        @(negedge clk);
        exp_grant = '0;
        exp_fire  = '0;
        exp_pop   = '0;
        for (int i = 0; i < NP; i++) begin
            nreq = 0;
            for (int o = 0; o < NP; o++) nreq = nreq + int'(req_bit(i, o));
            assert (nreq <= 1) else $error("illegal multi-bit req on input %0d", i);
        end
        for (int o = 0; o < NP; o++) begin
            if (m_owner[o] >= 0) begin
                exp_grant = exp_grant | (NR'(1) << (o * NP + m_owner[o]));
                if (req_bit(m_owner[o], o) && m_cred[o] > 0) begin
                    exp_fire = exp_fire | (NP'(1) << o);
                    exp_pop  = exp_pop | (NP'(1) << m_owner[o]);
                end
            end
        end
        chk("model_grant", 32'(bus.grant), 32'(exp_grant));
        chk("model_fire",  32'(bus.fire),  32'(exp_fire));
        chk("model_pop",   32'(bus.pop),   32'(exp_pop));
        chk("model_err",   32'(bus.err),   32'(m_err));
    end

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.tail     = '0;
        bus.cred_ret = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: quiet after reset
        repeat (10) begin
            @(negedge clk);
            chk("t1_quiet", 32'({bus.grant, bus.fire, bus.pop, bus.err}), 32'd0);
        end

        // 2: three inputs contend for output 3, 2-flit packets
        auto_ret = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 2;
            dst[i] = 3;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_grant3", 32'(bus.grant[15:12]), 32'(T2_GRANT[k]));
            chk("t2_fire3",  32'(bus.fire[3]),      32'(T2_FIRE[k]));
        end
        repeat (3) @(negedge clk);

        // 3: credit exhaustion on output 1 and single-credit resume
        auto_ret = '0;
        rem[2] = 6;
        dst[2] = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_grant1", 32'(bus.grant[7:4]), (k == 0) ? 32'd0 : 32'd4);
            chk("t3_fire1",  32'(bus.fire[1]),    32'(k >= 1 && k <= 4));
            chk("t3_pop2",   32'(bus.pop[2]),     32'(k >= 1 && k <= 4));
        end
        man_ret = 4'b0010;
        @(negedge clk);
        chk("t3_fire_ret_cycle", 32'(bus.fire[1]), 32'd0);
        @(negedge clk);
        chk("t3_fire_after_ret", 32'(bus.fire[1]), 32'd1);
        @(negedge clk);
        chk("t3_fire_restall", 32'(bus.fire[1]), 32'd0);
        chk("t3_grant_held",   32'(bus.grant[7:4]), 32'd4);
        auto_ret = '1;
        repeat (10) @(negedge clk);

        // 4: independent outputs granted in the same cycle
        rem[0] = 3; dst[0] = 0;
        rem[1] = 3; dst[1] = 1;
        @(negedge clk);
        chk("t4_grant_t", 32'(bus.grant), 32'd0);
        @(negedge clk);
        chk("t4_grant", 32'(bus.grant), 32'h0021);
        chk("t4_fire",  32'(bus.fire),  32'b0011);
        chk("t4_pop",   32'(bus.pop),   32'b0011);
        repeat (8) @(negedge clk);

        // 5: credit return at full count sets sticky err, counter saturates
        auto_ret = 4'b1110;
        man_ret  = 4'b0001;
        @(negedge clk);
        chk("t5_err_before", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("t5_err_set", 32'(bus.err), 32'd1);
        rem[3] = 6;
        dst[3] = 0;
        nf = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.fire[0]) nf++;
        end
        chk("t5_fires_saturated", 32'(nf), 32'd4);
        chk("t5_grant_held", 32'(bus.grant[3:0]), 32'b1000);
        // owner's buffer runs dry mid-packet: ownership kept, nothing fires
        rem[3] = 0;
        auto_ret = '1;
        repeat (4) @(negedge clk);
        chk("t5_empty_fire", 32'(bus.fire[0]), 32'd0);
        chk("t5_empty_grant", 32'(bus.grant[3:0]), 32'b1000);
        chk("t5_empty_pop", 32'(bus.pop[3]), 32'd0);

        // 6: asynchronous reset mid-packet
        rem[1] = 8;
        dst[1] = 2;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        chk("t6_pre_grant", 32'(bus.grant[11:8]), 32'b0010);
        chk("t6_pre_fire",  32'(bus.fire[2]),     32'd1);
        chk("t6_pre_err",   32'(bus.err),         32'd1);
        rst_n = 1'b0;
        for (int i = 0; i < NP; i++) rem[i] = 0;
        #1;
        chk("t6_rst_grant", 32'(bus.grant), 32'd0);
        chk("t6_rst_fire",  32'(bus.fire),  32'd0);
        chk("t6_rst_pop",   32'(bus.pop),   32'd0);
        chk("t6_rst_err",   32'(bus.err),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rem[0] = 2; dst[0] = 1;
        rem[2] = 2; dst[2] = 1;
        @(negedge clk);
        chk("t6_post_t", 32'(bus.grant[7:4]), 32'd0);
        @(negedge clk);
        chk("t6_post_rr", 32'(bus.grant[7:4]), 32'b0001);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
